serial_unsigned_adder: RTL

- Bit-serial unsigned adder; the additive counterpart of the team's combinational unsigned subtractor.
- Adds two WIDTH-bit operands LSB-first, one bit per clock, using a single full-adder cell and a carry flop.
- Used where area matters more than latency, e.g. accumulating results in small FPGA datapaths.
- Start/busy/done handshake; result and carry-out are held until the next completed operation.

---
 rtl/serial_unsigned_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_unsigned_adder.sv
// serial_unsigned_adder
//   Bit-serial unsigned adder. Operands are captured on an accepted start,
//   then added LSB-first, one bit per clock, through a single full-adder
//   cell and a carry flop. The result is published once, on entry to DONE,
//   and held until the next completed operation.
//
//   State table
//     IDLE  | waiting for start; operands latched on the accepting edge
//     SHIFT | one full-adder step per cycle, LSB first
//     DONE  | done pulse; SUM/COUT freshly valid; back to IDLE next cycle
//
// Ports
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   start : begin an addition (sampled in IDLE only)
//   A, B  : WIDTH-bit unsigned operands (sampled on the accepted start only)
//   busy  : high in SHIFT and DONE
//   done  : one-cycle pulse when SUM/COUT update
//   SUM   : (A+B) mod 2^WIDTH of the last completed operation
//   COUT  : carry out of the MSB of the last completed operation
module serial_unsigned_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             c_next;
  logic [WIDTH-1:0] rs_next;

  // Single full-adder cell working on the current LSBs.
  always_comb begin
    s_bit   = ra[0] ^ rb[0] ^ c;
    c_next  = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    rs_next = {s_bit, rs[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ra    <= '0;
      rb    <= '0;
      rs    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      SUM   <= '0;
      COUT  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ra    <= A;
            rb    <= B;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          c   <= c_next;
          rs  <= rs_next;
          ra  <= {1'b0, ra[WIDTH-1:1]};
          rb  <= {1'b0, rb[WIDTH-1:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Publish from the final step's values so partial sums never
            // reach SUM and the outputs stay purely registered.
            SUM   <= rs_next;
            COUT  <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
